// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and R/W bit values.
// Used by the target controller and by the transaction controller on the far end.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_LOAD,
    TX_BYTE,
    TX_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_ctrl_if.sv
// Local byte-stream side of the I2C target plus a state debug tap.
// Handshake: a tx byte transfers on a clock edge where tx_req_o and tx_valid_i are both high.
interface i2c_target_ctrl_if;
  import i2c_pkg::*;

  logic       start_o;
  logic       stop_o;
  logic       selected_o;
  logic       rw_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       ack_en_i;
  logic       tx_req_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       master_nack_o;
  i2c_state_e state_o;

  modport slave (
    output start_o, stop_o, selected_o, rw_o, rx_data_o, rx_valid_o,
    output tx_req_o, master_nack_o, state_o,
    input  ack_en_i, tx_data_i, tx_valid_i
  );

  modport master (
    input  start_o, stop_o, selected_o, rw_o, rx_data_o, rx_valid_o,
    input  tx_req_o, master_nack_o, state_o,
    output ack_en_i, tx_data_i, tx_valid_i
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SDA/SCL, registers them once more and derives SCL edges
// plus START (SDA falls, SCL high) and STOP (SDA rises, SCL high).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic                   sda_prev_q;
  logic                   scl_prev_q;
  logic                   sda_s;
  logic                   scl_s;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_sync_q <= '1;
      scl_sync_q <= '1;
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
    end else begin
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_prev_q <= sda_s;
      scl_prev_q <= scl_s;
    end
  end

  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = ~sda_s & sda_prev_q & scl_s;
  assign stop_o     = sda_s & ~sda_prev_q & scl_s;

endmodule

// File: rtl/i2c_target_ctrl.sv
// Byte-level I2C target: address match, rx/tx byte shifting, ACK handling
// and SCL stretching while the local side has no tx byte ready.
module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  inout  wire               sda_io,
  inout  wire               scl_io,
  i2c_target_ctrl_if.slave  bus_if
);

  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sda_i      (sda_io),
    .scl_i      (scl_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_ev),
    .stop_o     (stop_ev)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       byte_done_q, byte_done_d;
  logic       ack_q, ack_d;
  logic       sda_low_q, sda_low_d;
  logic       scl_low_q, scl_low_d;
  logic       selected_q, selected_d;
  logic       rw_q, rw_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       nack_q, nack_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      byte_done_q <= 1'b0;
      ack_q       <= 1'b0;
      sda_low_q   <= 1'b0;
      scl_low_q   <= 1'b0;
      selected_q  <= 1'b0;
      rw_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      byte_done_q <= byte_done_d;
      ack_q       <= ack_d;
      sda_low_q   <= sda_low_d;
      scl_low_q   <= scl_low_d;
      selected_q  <= selected_d;
      rw_q        <= rw_d;
      rx_valid_q  <= rx_valid_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      nack_q      <= nack_d;
    end
  end

  // byte_done_q marks "last bit sampled, act on the next scl_fall".
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    byte_done_d = byte_done_q;
    ack_d       = ack_q;
    sda_low_d   = sda_low_q;
    scl_low_d   = scl_low_q;
    selected_d  = selected_q;
    rw_d        = rw_q;
    rx_valid_d  = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    nack_d      = 1'b0;
    if (start_ev) begin
      start_d     = 1'b1;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_low_d   = 1'b0;
      scl_low_d   = 1'b0;
      selected_d  = 1'b0;
      state_d     = ADDR;
    end else if (stop_ev) begin
      stop_d      = 1'b1;
      byte_done_d = 1'b0;
      sda_low_d   = 1'b0;
      scl_low_d   = 1'b0;
      selected_d  = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              sda_low_d = 1'b1;
              state_d   = ADDR_ACK;
            end else begin
              state_d   = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_low_d  = 1'b0;
            selected_d = 1'b1;
            rw_d       = shift_q[0];
            // SCL is low here; start stretching at once for a read.
            scl_low_d  = (shift_q[0] == RW_READ);
            state_d    = (shift_q[0] == RW_READ) ? TX_LOAD : RX_BYTE;
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = {shift_q[6:0], sda_s};
              rx_valid_d  = 1'b1;
              ack_d       = bus_if.ack_en_i;
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_low_d   = ack_q;
            state_d     = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = RX_BYTE;
          end
        end
        TX_LOAD: begin
          if (bus_if.tx_valid_i) begin
            shift_d   = bus_if.tx_data_i;
            sda_low_d = ~bus_if.tx_data_i[7];
            scl_low_d = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = TX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = TX_ACK;
            end else begin
              sda_low_d = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && !byte_done_q) begin
            if (!sda_s) begin
              byte_done_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = IGNORE;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            scl_low_d   = 1'b1;
            state_d     = TX_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_io = sda_low_q ? 1'b0 : 1'bz;
  assign scl_io = scl_low_q ? 1'b0 : 1'bz;

  assign bus_if.start_o       = start_q;
  assign bus_if.stop_o        = stop_q;
  assign bus_if.selected_o    = selected_q;
  assign bus_if.rw_o          = rw_q;
  assign bus_if.rx_data_o     = rx_data_q;
  assign bus_if.rx_valid_o    = rx_valid_q;
  assign bus_if.tx_req_o      = (state_q == TX_LOAD);
  assign bus_if.master_nack_o = nack_q;
  assign bus_if.state_o       = state_q;

endmodule

// File: doc/i2c_target_ctrl.md
Name: i2c_target_ctrl

Overview:
- Byte-level I2C target (slave) controller. It is the far end of the bus driven by i2c_transaction_ctrl.
- Detects START, repeated START and STOP; matches a fixed 7-bit address; shifts bytes in and out on open-drain sda_io/scl_io.
- Gives the local side a byte-stream interface: rx bytes out, tx bytes in.
- Stretches SCL while waiting for transmit data.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this block answers to.
- SYNC_STAGES, 2, flop count of the SDA/SCL input synchronisers (minimum 2).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- sda_io  inout  1  I2C data, open-drain (drives 0 or 'z)
- scl_io  inout  1  I2C clock, open-drain (drives 0 only while stretching)
- start_o  output  1  one-cycle pulse on START or repeated START
- stop_o  output  1  one-cycle pulse on STOP
- selected_o  output  1  high from address ACK until the next START or STOP
- rw_o  output  1  R/W bit of the current addressed transfer (1 = master reads)
- rx_data_o  output  8  last byte written by master, MSB first
- rx_valid_o  output  1  one-cycle pulse, rx_data_o valid
- ack_en_i  input  1  sampled at the 8th rx bit: 1 = ACK the byte, 0 = NACK
- tx_req_o  output  1  high while a tx byte is needed
- tx_data_i  input  8  byte to send to master
- tx_valid_i  input  1  accepted when tx_req_o & tx_valid_i
- master_nack_o  output  1  one-cycle pulse when master NACKs a tx byte

Behaviour:
- Inputs are synchronised through SYNC_STAGES flops, then registered once more for edge detection.
  - scl_rise/scl_fall/sda_rise/sda_fall are computed on the synchronised values.
- Bus events, valid in every state:
  - START: sda_fall with SCL high.
  - STOP: sda_rise with SCL high.
  - On START: pulse start_o, clear the bit counter, release SDA, go to ADDR. This applies even mid-byte.
  - On STOP: pulse stop_o, release both lines, go to IDLE, drop selected_o.
- Bit rules:
  - Sample SDA on scl_rise.
  - Change driven SDA only on the cycle after scl_fall.
  - Bits are MSB first; a 3-bit counter wraps after 8 bits.
- FSM:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match: go to ADDR_ACK and drive SDA low after the scl_fall following the 8th bit.
    - Mismatch: go to IGNORE, which releases the bus and waits only for START/STOP.
  - ADDR_ACK:
    - Release SDA on the next scl_fall, set selected_o, latch rw_o.
    - rw_o=0: go to RX_BYTE.
    - rw_o=1: go to TX_LOAD.
  - RX_BYTE:
    - After the 8th scl_rise: update rx_data_o, pulse rx_valid_o in the same cycle, latch ack_en_i.
    - On the following scl_fall: drive SDA low if ack_en_i was 1, else leave it released. Go to RX_ACK.
  - RX_ACK: release SDA on the next scl_fall, go to RX_BYTE.
  - TX_LOAD:
    - Assert tx_req_o.
    - Hold scl_io low (stretch) until tx_valid_i; SCL is already low on entry because it is reached after scl_fall.
    - On the handshake: load the shift register, drop tx_req_o, drive bit 7, release SCL the next cycle, go to TX_BYTE.
    - If tx_valid_i is already high on entry, the handshake completes in the entry cycle with no stretch beyond 1 clk.
  - TX_BYTE:
    - Shift out on each scl_fall.
    - After the 8th scl_fall, release SDA and go to TX_ACK.
  - TX_ACK:
    - Sample on scl_rise.
    - SDA=0: go to TX_LOAD at the next scl_fall.
    - SDA=1: pulse master_nack_o and go to IGNORE, waiting for STOP/repeated START.
- Reset (synchronous, any state): next edge goes to IDLE, releases SDA and SCL, and sets every output to 0, including rx_data_o = 8'h00.
- Simultaneous events:
  - A START/STOP detected in the same cycle as scl_rise takes priority over bit sampling.
  - A STOP during TX_LOAD stretch releases SCL immediately; tx_req_o drops without a handshake.

Decomposition:
- Package i2c_pkg holds:
  - the FSM state typedef (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE);
  - the R/W bit constants.
  - i2c_transaction_ctrl reuses the package.
- One natural sub-module, i2c_line_sync: synchroniser plus edge/START/STOP detector for SDA and SCL.
- Tristate assigns stay in the top level.

Test Plan:
- Write: START, 8'hA0 (0x50, W), 8'h3C with ack_en_i=1, STOP -> address ACK; rx_valid_o pulses once with rx_data_o=8'h3C; master sees ACK; start_o and stop_o each pulse once.
- Wrong address: START, 8'hA2, 8'h11, STOP -> SDA never driven; no rx_valid_o; selected_o stays 0; master sees NACK on address.
- Read with stretch: START, 8'hA1, tx_valid_i delayed 200 clk with tx_data_i=8'hA5, then master NACKs -> SCL held low ~200 clk; master reads 8'hA5; master_nack_o pulses.
- Write then repeated START read: 8'hA0, 8'h01, Sr, 8'hA1, read 8'h5A (ACK), 8'hC3 (NACK), STOP -> two start_o pulses; rx_data_o=8'h01; tx_req_o asserted twice.
- rx NACK: write 8'hFF with ack_en_i=0 -> master sees NACK on the data byte; rx_valid_o still pulses.
- Reset mid-read while TX_LOAD is stretching -> SCL and SDA released the next cycle; state IDLE; all outputs 0.
